mask_expand: RTL and testbench

Sparse-to-dense expander for the post-sparsity datapath, and the counterpart of the mask-update stage. It accepts a `length`-bit sparsity mask and a packed vector of up to `num_vals` fixed-point values, then scatters them into a dense `length`-entry vector. Packed value k goes to the position of the k-th set mask bit, counting from bit 0; unset positions become zero. It uses the same `input_ready`/`output_taken` handshake and `state` debug output as the rest of the sparsity blocks.

---
 rtl/mask_expand.sv | 97 +++++++++
 tb/tb_mask_expand.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mask_expand.sv
// mask_expand: scatters packed values into a dense vector at the set positions of a sparsity mask,
// walking one mask bit per cycle behind an input_ready/output_taken handshake.
module mask_expand #(
   parameter int IL       = 4,
   parameter int FL       = 16,
   parameter int length   = 32,
   parameter int num_vals = 16,
   parameter int p_length = $clog2(length)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [length-1:0]                   i_mask,
   input  logic [num_vals-1:0][IL+FL-1:0]      in,
   input  logic                                input_ready,
   input  logic                                output_taken,
   output logic [length-1:0][IL+FL-1:0]        o_data,
   output logic                                output_ready,
   output logic [p_length:0]                   o_count,
   output logic                                overflow,
   output logic [1:0]                          state
);
   localparam int PW = (num_vals > 1) ? $clog2(num_vals) : 1;
   localparam logic [p_length:0]   NV   = (p_length+1)'(num_vals);
   localparam logic [p_length:0]   LEN  = (p_length+1)'(length);
   localparam logic [p_length:0]   ONE  = (p_length+1)'(1);
   localparam logic [p_length-1:0] LAST = p_length'(length - 1);
   localparam logic [p_length-1:0] STEP = p_length'(1);

   typedef enum logic [1:0] {IDLE = 2'b00, EXPAND = 2'b01, DONE = 2'b10} state_t;

   state_t                           state_q;
   logic [length-1:0]                mask_q;
   logic [num_vals-1:0][IL+FL-1:0]   vals_q;
   logic [length-1:0][IL+FL-1:0]     data_q;
   logic [p_length-1:0]              idx_q;
   logic [p_length:0]                ptr_q, cnt_q;
   logic                             ovf_q, rdy_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         vals_q  <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (input_ready) begin
               mask_q  <= i_mask;
               vals_q  <= in;
               data_q  <= '0;
               idx_q   <= '0;
               ptr_q   <= '0;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
               state_q <= EXPAND;
            end
            EXPAND: begin
               // set bits beyond the packed capacity are zero-filled and flagged
               if (mask_q[idx_q]) begin
                  if (ptr_q < NV) begin
                     data_q[idx_q] <= vals_q[ptr_q[PW-1:0]];
                     ptr_q         <= ptr_q + ONE;
                  end else begin
                     data_q[idx_q] <= '0;
                     ovf_q         <= 1'b1;
                  end
                  cnt_q <= (cnt_q == LEN) ? cnt_q : cnt_q + ONE;
               end else begin
                  data_q[idx_q] <= '0;
               end
               if (idx_q == LAST) begin
                  state_q <= DONE;
                  rdy_q   <= 1'b1;
               end else begin
                  idx_q <= idx_q + STEP;
               end
            end
            DONE: if (output_taken) begin
               state_q <= IDLE;
               rdy_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_data       = data_q;
   assign output_ready = rdy_q;
   assign o_count      = cnt_q;
   assign overflow     = ovf_q;
   assign state        = state_q;
endmodule

// File: tb/tb_mask_expand.sv
// tb_mask_expand: table-driven and randomized checks of mask_expand against a queue-based scatter model.
module tb_mask_expand;
   localparam int W = 20, L = 32, N = 16;

   logic                    clk = 1'b0, reset = 1'b0;
   logic [L-1:0]            i_mask = '0;
   logic [N-1:0][W-1:0]     in_v = '0;
   logic                    input_ready = 1'b0, output_taken = 1'b0;
   logic [L-1:0][W-1:0]     o_data;
   logic                    output_ready;
   logic [5:0]              o_count;
   logic                    overflow;
   logic [1:0]              state;
   int                      tests = 0, fails = 0;

   mask_expand dut (
      .clk(clk), .reset(reset), .i_mask(i_mask), .in(in_v),
      .input_ready(input_ready), .output_taken(output_taken),
      .o_data(o_data), .output_ready(output_ready), .o_count(o_count),
      .overflow(overflow), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] mask;
      int          mode;
      int          cnt;
      bit          ovf;
      string       name;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0][W-1:0] pattern(input int mode);
      logic [N-1:0][W-1:0] v;
      for (int k = 0; k < N; k++)
         v[k] = (mode == 0) ? W'(k + 1) : (mode == 1) ? W'(-(k + 1)) : W'($urandom);
      return v;
   endfunction

   task automatic accept(input logic [L-1:0] m, input logic [N-1:0][W-1:0] v, input string name);
      @(negedge clk);
      i_mask = m;
      in_v = v;
      input_ready = 1'b1;
      @(negedge clk);
      input_ready = 1'b0;
      i_mask = $urandom;
      in_v = pattern(2);
      chk({name, " state after accept"}, 64'(state), 64'(2'b01));
   endtask

   task automatic expand(input logic [L-1:0] m, input logic [N-1:0][W-1:0] v,
                         input int ecnt, input bit eovf, input string name);
      logic [W-1:0]        q[$];
      logic [L-1:0][W-1:0] exp_d;
      int                  lat, bad;
      q = {};
      for (int k = 0; k < N; k++) q.push_back(v[k]);
      for (int i = 0; i < L; i++) begin
         exp_d[i] = '0;
         if (m[i] && q.size() > 0) exp_d[i] = q.pop_front();
      end
      accept(m, v, name);
      lat = 0;
      while (!output_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, 64'(lat), 64'(L));
      bad = -1;
      for (int i = 0; i < L; i++)
         if (bad < 0 && o_data[i] !== exp_d[i]) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s data[%0d]: got %0h expected %0h", name, bad, o_data[bad], exp_d[bad]);
      end
      chk({name, " o_count"}, 64'(o_count), 64'(ecnt));
      chk({name, " overflow"}, 64'(overflow), 64'(eovf));
      chk({name, " state done"}, 64'(state), 64'(2'b10));
   endtask

   task automatic release_out(input string name);
      output_taken = 1'b1;
      @(negedge clk);
      output_taken = 1'b0;
      chk({name, " state idle"}, 64'(state), 64'(2'b00));
      chk({name, " ready low"}, 64'(output_ready), 64'(0));
   endtask

   initial begin
      vec_t                vecs[5];
      logic [L-1:0]        m;
      logic [N-1:0][W-1:0] v;
      vecs[0] = '{32'hAAAAAAAA, 0, 16, 1'b0, "alternating"};
      vecs[1] = '{32'h0000FFFF, 1, 16, 1'b0, "low_half"};
      vecs[2] = '{32'b01001001110101011011010011011011, 0, 18, 1'b1, "overflow"};
      vecs[3] = '{32'hFFFFFFFF, 1, 32, 1'b1, "full"};
      vecs[4] = '{32'h80000001, 0, 2, 1'b0, "edges"};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset state", 64'(state), 64'(0));
      chk("reset ready", 64'(output_ready), 64'(0));
      chk("reset count", 64'(o_count), 64'(0));
      chk("reset overflow", 64'(overflow), 64'(0));
      chk("reset data nonzero", 64'(o_data != '0), 64'(0));
      reset = 1'b1;

      for (int t = 0; t < 5; t++) begin
         expand(vecs[t].mask, pattern(vecs[t].mode), vecs[t].cnt, vecs[t].ovf, vecs[t].name);
         release_out(vecs[t].name);
      end

      expand('0, pattern(0), 0, 1'b0, "empty");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("empty hold state", 64'(state), 64'(2'b10));
      end
      i_mask = '1;
      in_v = pattern(0);
      input_ready = 1'b1;
      output_taken = 1'b1;
      @(negedge clk);
      input_ready = 1'b0;
      output_taken = 1'b0;
      chk("both high state", 64'(state), 64'(2'b00));
      chk("both high ready", 64'(output_ready), 64'(0));
      @(negedge clk);
      chk("both high no accept", 64'(state), 64'(2'b00));
      chk("both high count kept", 64'(o_count), 64'(0));

      accept('1, pattern(0), "midreset");
      repeat (10) @(negedge clk);
      chk("midreset in expand", 64'(state), 64'(2'b01));
      reset = 1'b0;
      #1;
      chk("midreset state", 64'(state), 64'(0));
      chk("midreset ready", 64'(output_ready), 64'(0));
      chk("midreset count", 64'(o_count), 64'(0));
      chk("midreset overflow", 64'(overflow), 64'(0));
      chk("midreset data nonzero", 64'(o_data != '0), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      expand(32'h12345678, pattern(1), 13, 1'b0, "after_reset");
      release_out("after_reset");

      for (int r = 0; r < 20; r++) begin
         m = (r % 3 == 0) ? $urandom & $urandom : (r % 3 == 1) ? $urandom | $urandom : $urandom;
         v = pattern(2);
         expand(m, v, $countones(m), $countones(m) > N, $sformatf("rand%0d", r));
         release_out($sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
